// File: rtl/loa_byte_serial_adder.sv
// Byte-serial 32-bit Lower-part-OR Adder: low APPROX_BYTES bytes are A|B, the
// exact upper bytes are summed one per cycle through a single shared 8-bit RCA.

module rca_8bits (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);
    logic [8:0] c;

    assign c[0] = cin_i;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_fa
            assign sum_o[g]  = a_i[g] ^ b_i[g] ^ c[g];
            assign c[g+1]    = (a_i[g] & b_i[g]) | (c[g] & (a_i[g] ^ b_i[g]));
        end
    endgenerate

    assign cout_o = c[8];
endmodule

module loa_byte_serial_adder #(
    parameter int APPROX_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_cout
);
    // Top bit of the OR'd region seeds the exact-part carry; unused when APPROX_BYTES==0.
    localparam int         CIDX = (APPROX_BYTES > 0) ? 8 * APPROX_BYTES - 1 : 0;
    localparam logic [1:0] IDX0 = 2'(APPROX_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        carry_q, carry_d;
    logic [1:0]  idx_q, idx_d;

    logic [7:0]  rca_a, rca_b, rca_sum;
    logic        rca_cout;

    assign rca_a = a_q[{idx_q, 3'b000} +: 8];
    assign rca_b = b_q[{idx_q, 3'b000} +: 8];

    rca_8bits u_rca (
        .a_i    (rca_a),
        .b_i    (rca_b),
        .cin_i  (carry_q),
        .sum_o  (rca_sum),
        .cout_o (rca_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = in_a;
                    b_d = in_b;
                    for (int i = 0; i < 4; i++) begin
                        if (i < APPROX_BYTES)
                            sum_d[8*i +: 8] = in_a[8*i +: 8] | in_b[8*i +: 8];
                        else
                            sum_d[8*i +: 8] = 8'h00;
                    end
                    carry_d = (APPROX_BYTES == 0) ? in_cin : (in_a[CIDX] & in_b[CIDX]);
                    idx_d   = IDX0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                sum_d[{idx_q, 3'b000} +: 8] = rca_sum;
                carry_d = rca_cout;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    cout_d  = rca_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
endmodule

// File: tb/tb_loa_byte_serial_adder.sv
// Scoreboard bench: index 1 drives an APPROX_BYTES=1 instance, index 0 an
// APPROX_BYTES=0 instance; a negedge monitor checks results and latency.

module tb_loa_byte_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_a      [2];
    logic [31:0] in_b      [2];
    logic        in_cin    [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_sum   [2];
    logic        out_cout  [2];

    loa_byte_serial_adder #(.APPROX_BYTES(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_cin(in_cin[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_sum(out_sum[1]), .out_cout(out_cout[1])
    );

    loa_byte_serial_adder #(.APPROX_BYTES(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_cin(in_cin[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_sum(out_sum[0]), .out_cout(out_cout[0])
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
    } exp_t;

    exp_t expq [2][$];
    int   acc  [2][$];
    int   hs   [2];
    logic ov_prev [2];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                ov_prev[d] = 1'b0;
            end else begin
                if (in_valid[d] && in_ready[d])
                    acc[d].push_back(cyc + 1);
                if (out_valid[d] && !ov_prev[d] && acc[d].size() > 0)
                    chk($sformatf("latency%0d", d), 33'(cyc - acc[d][acc[d].size()-1]), 33'(4 - d));
                if (out_valid[d] && out_ready[d]) begin
                    if (expq[d].size() == 0) begin
                        chk($sformatf("spurious_out%0d", d), 33'(1), 33'(0));
                    end else begin
                        mon_e = expq[d].pop_front();
                        chk($sformatf("result%0d", d), {out_cout[d], out_sum[d]}, {mon_e.cout, mon_e.sum});
                    end
                    hs[d]++;
                end
                ov_prev[d] = out_valid[d];
            end
        end
    end

    task automatic wait_ready(input int d);
        int n = 0;
        while (!in_ready[d] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk($sformatf("ready_timeout%0d", d), 33'(in_ready[d]), 33'(1));
    endtask

    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic [31:0] es, input logic ec);
        exp_t e;
        wait_ready(d);
        e.sum  = es;
        e.cout = ec;
        expq[d].push_back(e);
        in_valid[d] = 1'b1;
        in_a[d]     = a;
        in_b[d]     = b;
        in_cin[d]   = cin;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (expq[d].size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("drain%0d", d), 33'(expq[d].size()), 33'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, h0, n;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; in_a[d] = '0; in_b[d] = '0;
            in_cin[d] = 1'b0; out_ready[d] = 1'b1; hs[d] = 0; ov_prev[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_in_ready%0d", d), 33'(in_ready[d]), 33'(1));
            chk($sformatf("rst_out_valid%0d", d), 33'(out_valid[d]), 33'(0));
            chk($sformatf("rst_out%0d", d), {out_cout[d], out_sum[d]}, 33'(0));
        end

        // APPROX_BYTES=1 directed vectors
        send(1, 32'h000000FF, 32'h00000081, 1'b0, 32'h000001FF, 1'b0);
        send(1, 32'hFFFFFF00, 32'h00000100, 1'b0, 32'h00000000, 1'b1);
        send(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
        drain(1);

        // APPROX_BYTES=0: carry-in is live
        send(0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
        send(0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0);
        send(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0);
        drain(0);

        // backpressure in DONE
        out_ready[1] = 1'b0;
        n0 = acc[1].size();
        h0 = hs[1];
        send(1, 32'h12345678, 32'h11111111, 1'b0, 32'h23456779, 1'b0);
        n = 0;
        while (!out_valid[1] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_reach_done", 33'(out_valid[1]), 33'(1));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", {out_cout[1], out_sum[1]}, {1'b0, 32'h23456779});
            chk("bp_in_ready", 33'(in_ready[1]), 33'(0));
            chk("bp_out_valid", 33'(out_valid[1]), 33'(1));
            in_valid[1] = ~in_valid[1];
            in_a[1] = $urandom;
            in_b[1] = $urandom;
        end
        in_valid[1] = 1'b0;
        chk("bp_no_accept", 33'(acc[1].size()), 33'(n0 + 1));
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 33'(in_ready[1]), 33'(1));
        chk("bp_release_out_valid", 33'(out_valid[1]), 33'(0));
        chk("bp_one_handshake", 33'(hs[1]), 33'(h0 + 1));
        chk("bp_sum_kept", {out_cout[1], out_sum[1]}, {1'b0, 32'h23456779});

        // reset one cycle after accept
        send(1, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'h0, 1'b0);
        void'(expq[1].pop_back());
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        chk("abort_in_ready", 33'(in_ready[1]), 33'(1));
        chk("abort_out_valid", 33'(out_valid[1]), 33'(0));
        chk("abort_out", {out_cout[1], out_sum[1]}, 33'(0));
        send(1, 32'h80000080, 32'h80000080, 1'b0, 32'h00000180, 1'b1);
        drain(1);

        // back-to-back with in_valid held high
        in_cin[1] = 1'b1;
        wait_ready(1);
        n0 = acc[1].size();
        h0 = hs[1];
        mon_e.sum = 32'h00000030; mon_e.cout = 1'b0;
        expq[1].push_back(mon_e);
        in_valid[1] = 1'b1; in_a[1] = 32'h00000010; in_b[1] = 32'h00000020;
        @(posedge clk); #1;
        mon_e.sum = 32'h02020201; mon_e.cout = 1'b0;
        expq[1].push_back(mon_e);
        in_a[1] = 32'h01010101; in_b[1] = 32'h01010101;
        wait_ready(1);
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        drain(1);
        chk("b2b_accepts", 33'(acc[1].size()), 33'(n0 + 2));
        if (acc[1].size() >= 2)
            chk("b2b_spacing", 33'(acc[1][acc[1].size()-1] - acc[1][acc[1].size()-2]), 33'(5));
        chk("b2b_pulses", 33'(hs[1]), 33'(h0 + 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
